// File: rtl/port_tx_ctrl.sv
// port_tx_ctrl: drains one port FIFO and frames DA/SA/LEN/payload packets onto a valid/ready port.
// Optional feature macro PORT_TX_PKT_CNT_EN adds the 16-bit tx_pkt_cnt transmitted-packet counter.
module port_tx_ctrl #(
    parameter int unsigned W_WIDTH    = 8,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned SKID_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               port_en,
    input  logic               fifo_empty,
    output logic               fifo_rd_en,
    input  logic [W_WIDTH-1:0] fifo_rd_data,
    output logic [W_WIDTH-1:0] port_data,
    output logic               port_valid,
    output logic               port_sop,
    output logic               port_eop,
    input  logic               port_ready
`ifdef PORT_TX_PKT_CNT_EN
    ,
    output logic [15:0]        tx_pkt_cnt
`endif
);

    localparam int unsigned PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int unsigned CW = $clog2(SKID_DEPTH + RD_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_WAIT_LEN,
        S_PAYLOAD,
        S_DRAIN
    } state_t;

    state_t                r_state;
    logic [1:0]            r_hdr_cnt;
    logic [W_WIDTH-1:0]    r_pay_cnt;
    logic [RD_LAT-1:0]     r_tag_vld;
    logic [RD_LAT-1:0]     r_tag_sop;
    logic [RD_LAT-1:0]     r_tag_eop;
    logic [RD_LAT-1:0]     r_tag_len;
    logic [W_WIDTH-1:0]    r_mem_data [SKID_DEPTH];
    logic [SKID_DEPTH-1:0] r_mem_sop;
    logic [SKID_DEPTH-1:0] r_mem_eop;
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_occ;

    logic [CW-1:0]         w_inflight;
    logic                  w_rd_state;
    logic                  w_room;
    logic                  w_issue;
    logic                  w_iss_sop;
    logic                  w_iss_eop;
    logic                  w_iss_len;
    logic                  w_push;
    logic                  w_push_eop;
    logic                  w_len_ret;
    logic                  w_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(SKID_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Reads issued but not yet written into the buffer, including the one returning now.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + CW'(r_tag_vld[i]);
        end
    end

    assign w_rd_state = (r_state == S_HDR) || (r_state == S_PAYLOAD);
    assign w_room     = (r_occ + w_inflight) < CW'(SKID_DEPTH);
    assign w_issue    = !rst && !fifo_empty && w_rd_state && w_room;
    assign w_iss_sop  = (r_state == S_HDR) && (r_hdr_cnt == 2'd0);
    assign w_iss_len  = (r_state == S_HDR) && (r_hdr_cnt == 2'd2);
    assign w_iss_eop  = (r_state == S_PAYLOAD) && (r_pay_cnt == W_WIDTH'(1));

    assign w_push     = r_tag_vld[RD_LAT-1];
    assign w_len_ret  = w_push && r_tag_len[RD_LAT-1];
    // A zero LEN byte is itself the last byte of its packet.
    assign w_push_eop = r_tag_eop[RD_LAT-1] || (w_len_ret && (fifo_rd_data == '0));

    assign port_valid = (r_occ != '0);
    assign w_pop      = port_valid && port_ready;
    assign fifo_rd_en = w_issue;
    assign port_data  = port_valid ? r_mem_data[r_rd_ptr] : '0;
    assign port_sop   = port_valid && r_mem_sop[r_rd_ptr];
    assign port_eop   = port_valid && r_mem_eop[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= fifo_rd_data;
            r_mem_sop[r_wr_ptr]  <= r_tag_sop[RD_LAT-1];
            r_mem_eop[r_wr_ptr]  <= w_push_eop;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_hdr_cnt <= '0;
            r_pay_cnt <= '0;
            r_tag_vld <= '0;
            r_tag_sop <= '0;
            r_tag_eop <= '0;
            r_tag_len <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_occ     <= '0;
        end else begin
            r_tag_vld[0] <= w_issue;
            r_tag_sop[0] <= w_iss_sop;
            r_tag_eop[0] <= w_iss_eop;
            r_tag_len[0] <= w_iss_len;
            for (int i = 1; i < RD_LAT; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_sop[i] <= r_tag_sop[i-1];
                r_tag_eop[i] <= r_tag_eop[i-1];
                r_tag_len[i] <= r_tag_len[i-1];
            end

            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_push && !w_pop)      r_occ <= r_occ + CW'(1);
            else if (!w_push && w_pop) r_occ <= r_occ - CW'(1);

            case (r_state)
                S_IDLE: begin
                    r_hdr_cnt <= '0;
                    if (port_en && !fifo_empty) r_state <= S_HDR;
                end
                S_HDR: begin
                    if (w_issue) begin
                        r_hdr_cnt <= r_hdr_cnt + 2'd1;
                        if (r_hdr_cnt == 2'd2) r_state <= S_WAIT_LEN;
                    end
                end
                S_WAIT_LEN: begin
                    if (w_len_ret) begin
                        if (fifo_rd_data == '0) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_pay_cnt <= fifo_rd_data;
                            r_state   <= S_PAYLOAD;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (w_issue) begin
                        r_pay_cnt <= r_pay_cnt - W_WIDTH'(1);
                        if (r_pay_cnt == W_WIDTH'(1)) r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if ((r_occ == '0) && (w_inflight == '0)) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef PORT_TX_PKT_CNT_EN
    logic [15:0] r_pkt_cnt;

    always_ff @(posedge clk) begin
        if (rst)                      r_pkt_cnt <= '0;
        else if (w_pop && port_eop)   r_pkt_cnt <= r_pkt_cnt + 16'd1;
    end

    assign tx_pkt_cnt = r_pkt_cnt;
`endif

endmodule
